qrs_window_search: RTL and testbench

//   Upstream peak-search stage for alg_fsm. Consumes the short-window abs-diff sample stream.
//   In init, tracks the running maximum that seeds the QRS threshold.
//   In run, opens a fixed search window on a threshold crossing and reports the window

---
 rtl/qrs_window_search.sv | 127 ++++++++++++
 tb/tb_qrs_window_search.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/qrs_window_search.sv
// qrs_window_search: peak search over the short-window abs-diff stream.
// Tracks the running max during init. In run it opens a fixed-length search
// window on a threshold crossing, reports the window max and its sample index,
// then holds off for a refractory period before re-arming.
module qrs_window_search #(
  parameter int DATA_WIDTH  = 11,
  parameter int CTR_WIDTH   = 24,
  parameter int WIN_LEN     = 36,
  parameter int REFRACT_LEN = 72
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] i_abs_diff,
  input  logic [CTR_WIDTH-1:0]  i_ctr,
  input  logic                  i_search_en,
  input  logic [DATA_WIDTH-1:0] i_threshold,
  output logic [DATA_WIDTH-1:0] o_abs_diff_short_max,
  output logic                  o_abs_diff_short_valid,
  output logic                  o_extremum_found,
  output logic [CTR_WIDTH-1:0]  o_peak_ctr,
  output logic                  o_busy
);

  localparam int CNT_MAX = (WIN_LEN > REFRACT_LEN) ? WIN_LEN : REFRACT_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRACT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_WINDOW  = 3'd2,
    S_REPORT  = 3'd3,
    S_REFRACT = 3'd4
  } state_t;

  state_t                state_q, state_nxt;
  logic [DATA_WIDTH-1:0] max_q, max_nxt;
  logic [CTR_WIDTH-1:0]  peak_q, peak_nxt;
  logic [CNT_W-1:0]      win_q, win_nxt;
  logic [CNT_W-1:0]      ref_q, ref_nxt;
  logic                  valid_q, valid_nxt;
  logic                  found_q;

  // Next-state, running max and counter updates
  always_comb begin
    state_nxt = state_q;
    max_nxt   = max_q;
    peak_nxt  = peak_q;
    win_nxt   = win_q;
    ref_nxt   = ref_q;
    valid_nxt = valid_q;
    if (i_ce) valid_nxt = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (i_ce && (i_abs_diff > max_q)) begin
          max_nxt  = i_abs_diff;
          peak_nxt = i_ctr;
        end
        // Arming is a control-path event, not gated by the sample strobe.
        if (i_search_en) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (i_ce && i_search_en && (i_abs_diff > i_threshold)) begin
          max_nxt   = i_abs_diff;
          peak_nxt  = i_ctr;
          win_nxt   = CNT_ONE;
          state_nxt = (WIN_LEN == 1) ? S_REPORT : S_WINDOW;
        end
      end
      S_WINDOW: begin
        // search_en is deliberately ignored so a dip cannot abort the window.
        if (i_ce) begin
          win_nxt = win_q + CNT_ONE;
          if (i_abs_diff > max_q) begin
            max_nxt  = i_abs_diff;
            peak_nxt = i_ctr;
          end
          if (win_q == WIN_LAST) state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        ref_nxt   = '0;
        state_nxt = S_REFRACT;
      end
      S_REFRACT: begin
        if (i_ce) begin
          ref_nxt = ref_q + CNT_ONE;
          if (ref_q == REF_LAST) state_nxt = S_ARMED;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers with async active-low reset
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= S_IDLE;
      max_q   <= '0;
      peak_q  <= '0;
      win_q   <= '0;
      ref_q   <= '0;
      valid_q <= 1'b0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      max_q   <= max_nxt;
      peak_q  <= peak_nxt;
      win_q   <= win_nxt;
      ref_q   <= ref_nxt;
      valid_q <= valid_nxt;
      // Flop mirrors "in REPORT" so the pulse is glitch-free.
      found_q <= (state_nxt == S_REPORT);
    end
  end

  assign o_abs_diff_short_max   = max_q;
  assign o_peak_ctr             = peak_q;
  assign o_abs_diff_short_valid = valid_q;
  assign o_extremum_found       = found_q;
  assign o_busy = (state_q == S_WINDOW) || (state_q == S_REPORT) ||
                  (state_q == S_REFRACT);

endmodule

// File: tb/tb_qrs_window_search.sv
// Bench for qrs_window_search: directed scenarios followed by random traffic,
// every clock compared against a sample-queue reference model.
module tb_qrs_window_search;
  localparam int DW = 11;
  localparam int CW = 24;
  localparam int WIN_LEN = 36;
  localparam int REFRACT_LEN = 72;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          ce = 1'b0;
  logic [DW-1:0] abs_d = '0;
  logic [CW-1:0] ctr = '0;
  logic          en = 1'b0;
  logic [DW-1:0] th = '0;
  logic [DW-1:0] o_max;
  logic          o_valid, o_found, o_busy;
  logic [CW-1:0] o_peak;

  int checks = 0;
  int errors = 0;
  int npulse = 0;
  int p0;

  // reference model state
  bit          m_init, m_inwin, m_report, m_valid;
  int          m_ref_left;
  int unsigned m_max, m_peak;
  int unsigned wq_v[$];
  int unsigned wq_c[$];

  qrs_window_search #(.DATA_WIDTH(DW), .CTR_WIDTH(CW), .WIN_LEN(WIN_LEN),
                      .REFRACT_LEN(REFRACT_LEN)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_ce(ce), .i_abs_diff(abs_d), .i_ctr(ctr),
    .i_search_en(en), .i_threshold(th),
    .o_abs_diff_short_max(o_max), .o_abs_diff_short_valid(o_valid),
    .o_extremum_found(o_found), .o_peak_ctr(o_peak), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_init = 1; m_inwin = 0; m_report = 0; m_valid = 0;
    m_ref_left = 0; m_max = 0; m_peak = 0;
    wq_v.delete(); wq_c.delete();
  endfunction

  // max of the window so far; first occurrence wins ties
  function automatic void win_scan(output int unsigned mx, output int unsigned pk);
    mx = wq_v[0]; pk = wq_c[0];
    foreach (wq_v[i]) if (wq_v[i] > mx) begin mx = wq_v[i]; pk = wq_c[i]; end
  endfunction

  function automatic void model_close();
    int unsigned mx, pk;
    win_scan(mx, pk);
    m_max = mx; m_peak = pk;
    m_inwin = 0; m_report = 1;
  endfunction

  function automatic void model_step(bit c, int unsigned v, int unsigned idx,
                                     bit e, int unsigned t);
    if (c) m_valid = 1;
    if (m_init) begin
      if (c && v > m_max) begin m_max = v; m_peak = idx; end
      if (e) m_init = 0;
    end else if (m_inwin) begin
      if (c) begin
        wq_v.push_back(v); wq_c.push_back(idx);
        if (wq_v.size() == WIN_LEN) model_close();
      end
    end else if (m_report) begin
      m_report = 0; m_ref_left = REFRACT_LEN;
    end else if (m_ref_left > 0) begin
      if (c) m_ref_left--;
    end else if (c && e && v > t) begin
      wq_v.delete(); wq_c.delete();
      wq_v.push_back(v); wq_c.push_back(idx);
      if (WIN_LEN == 1) model_close(); else m_inwin = 1;
    end
  endfunction

  task automatic check_all();
    int unsigned mx, pk;
    if (m_inwin) win_scan(mx, pk); else begin mx = m_max; pk = m_peak; end
    chk("max",   32'(o_max),   mx);
    chk("peak",  32'(o_peak),  pk);
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("found", 32'(o_found), 32'(m_report));
    chk("busy",  32'(o_busy),  32'(m_inwin || m_report || (m_ref_left > 0)));
  endtask

  // one clock: drive, let the edge consume it, then compare
  task automatic tick(input bit c, input int unsigned v);
    ce = c; abs_d = DW'(v);
    @(posedge clk);
    #1;
    model_step(c, v, 32'(ctr), en, 32'(th));
    check_all();
    if (o_found) npulse++;
    if (c) ctr = ctr + 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_max",   32'(o_max),   0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_busy",  32'(o_busy),  0);
    chk("rst_found", 32'(o_found), 0);
    #10 nrst = 1'b1;

    // init tracking
    tick(0, 0);
    tick(1, 5);
    chk("t1_valid", 32'(o_valid), 1);
    tick(1, 100);
    tick(1, 40);
    tick(0, 999);
    chk("t1_max",  32'(o_max),  100);
    chk("t1_peak", 32'(o_peak), 1);
    chk("t1_npulse", 32'(npulse), 0);

    // window search
    th = 11'd50; en = 1'b1;
    tick(0, 0);
    ctr = 24'd1000;
    p0 = npulse;
    for (int k = 0; k < WIN_LEN; k++) begin
      if (k == 0) tick(1, 60);
      else if (k == 5 || k == 10) tick(1, 200);
      else begin
        if (k == 20) tick(0, 700);
        tick(1, 10);
      end
    end
    chk("t2_pulse", 32'(o_found), 1);
    chk("t2_max",   32'(o_max),  200);
    chk("t2_peak",  32'(o_peak), 1005);

    // refractory: report clock, then crossings at 10 and 60 are ignored, 73 opens
    tick(0, 0);
    chk("t2_single", 32'(o_found), 0);
    for (int k = 1; k <= 73; k++)
      tick(1, (k == 10 || k == 60 || k == 73) ? 300 : 10);
    chk("t4_busy", 32'(o_busy), 1);
    for (int k = 1; k < WIN_LEN; k++) tick(1, 10);
    chk("t4_pulse", 32'(o_found), 1);
    chk("t4_max",   32'(o_max), 300);
    chk("t4_npulse", 32'(npulse - p0), 2);
    tick(0, 0);
    for (int k = 0; k < REFRACT_LEN; k++) tick(1, 10);
    chk("t4_armed", 32'(o_busy), 0);

    // threshold equality
    tick(1, 50);
    chk("t3_eq", 32'(o_busy), 0);
    tick(1, 51);
    chk("t3_gt", 32'(o_busy), 1);
    for (int k = 1; k < WIN_LEN; k++) tick(1, 20);
    chk("t3_max", 32'(o_max), 51);
    tick(0, 0);
    for (int k = 0; k < REFRACT_LEN; k++) tick(1, 0);

    // search_en dip mid-window
    p0 = npulse;
    tick(1, 100);
    for (int k = 1; k < WIN_LEN; k++) begin
      en = (k == 11 || k == 12) ? 1'b0 : 1'b1;
      tick(1, (k == 11) ? 150 : 30);
    end
    chk("t5_pulse", 32'(o_found), 1);
    chk("t5_max",   32'(o_max), 150);
    tick(0, 0);
    for (int k = 0; k < REFRACT_LEN; k++) tick(1, 0);
    chk("t5_npulse", 32'(npulse - p0), 1);
    en = 1'b0;
    tick(1, 500);
    chk("t5_noarm", 32'(o_busy), 0);
    en = 1'b1;

    // async reset mid-window
    tick(1, 400);
    for (int k = 0; k < 5; k++) tick(1, 20);
    #2 nrst = 1'b0;
    #1;
    model_reset();
    chk("t6_max",   32'(o_max),   0);
    chk("t6_peak",  32'(o_peak),  0);
    chk("t6_valid", 32'(o_valid), 0);
    chk("t6_busy",  32'(o_busy),  0);
    chk("t6_found", 32'(o_found), 0);
    #1 nrst = 1'b1;
    en = 1'b0;
    p0 = npulse;
    for (int k = 0; k < 60; k++) tick(1, 300 + k);
    chk("t6_nopulse", 32'(npulse - p0), 0);
    chk("t6_idle", 32'(o_busy), 0);

    // random traffic, including full-scale samples and zero threshold
    for (int i = 0; i < 3000; i++) begin
      int unsigned r, v;
      if (i % 250 == 0) begin
        r = $urandom_range(0, 3);
        th = (r == 0) ? 11'd0 : DW'($urandom_range(100, 500));
      end
      en = ($urandom_range(0, 19) != 0);
      r = $urandom_range(0, 9);
      v = (r == 0) ? 2047 : (r == 1) ? 0 : $urandom_range(0, 600);
      tick($urandom_range(0, 3) != 0, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
